packet_demux_1_to_n: RTL
========================

# packet_demux_1_to_n

Routes a single AXI-stream packet stream to one of `NUM_OUT` outputs, using the channel-id field in `ctl`. A packet is the run of beats from `sop` through `eop`. This is the return-path counterpart of the N-to-1 packet arbitration tree: responses tagged with the arbiter-inserted channel id are steered back to the originating lane. Routing is locked per packet, and one registered skid stage decouples input `rdy` from output backpressure.

## Interface
- `DAT_BYTS`, 8, data width in bytes
- `DAT_BITS`, `DAT_BYTS*8`, data width in bits
- `CTL_BITS`, 8, sideband control width
- `NUM_OUT`, 8, number of output lanes (≥1)
- `LOG2_NUM_OUT`, `NUM_OUT==1 ? 1 : $clog2(NUM_OUT)`, channel-id width
- `SEL_BIT`, `CTL_BITS-LOG2_NUM_OUT`, LSB of the channel-id field in `ctl`
- `CLR_SEL`, 0, when 1 the channel-id field is zeroed on output `ctl`
- `i_clk`  in  1  sole clock
- `i_rst`  in  1  reset, asynchronous, active-high
- `i_axi`  if_axi_stream.sink  `dat/val/sop/eop/err/mod/ctl/rdy`  input stream
- `o_n_axi[NUM_OUT-1:0]`  if_axi_stream.source  same  output lanes
- `o_drop_cnt`  out  16  dropped-packet count (present only with `PACKET_DEMUX_DROP_EN`)

## Operation
- Transfer occurs when `val && rdy` on the clock edge.
- FSM states:
  - IDLE (between packets):
    - Any accepted beat is a packet start, whether or not `sop` is set.
    - Channel `sel = ctl[SEL_BIT +: LOG2_NUM_OUT]` is latched.
    - Single-beat packet (`sop && eop`): stay in IDLE.
    - Otherwise go to ACTIVE.
  - ACTIVE:
    - All beats route to the latched `sel`; `ctl` channel bits of later beats are ignored.
    - An accepted beat with `eop` returns the FSM to IDLE.
    - An accepted beat with `sop` (missing `eop`) re-latches `sel` from that beat and stays ACTIVE unless `eop` is also set.
- Accepted beats enter a 2-entry skid buffer, each entry tagged with its `sel`.
- The head entry drives only `o_n_axi[head.sel]`: `val=1` and all payload fields.
- All other lanes: `val=0`, payload driven to the head values (don't-care).
- Head pops when `o_n_axi[head.sel].rdy` is high.
- `i_axi.rdy` is registered: 1 iff the skid buffer holds fewer than 2 entries after the current cycle's push/pop.
- `CLR_SEL=1`: output `ctl[SEL_BIT +: LOG2_NUM_OUT]` is 0. All other fields pass unchanged, `err` and `mod` included.
- Out-of-range `sel` (≥`NUM_OUT`, non-power-of-2 only): behaviour is set under Configuration.
- Beat ordering is preserved. A stall on one lane blocks all lanes (no per-lane buffering).

## Timing
- Reset values:
  - FSM = IDLE, skid buffer empty.
  - All `o_n_axi[*].val=0`, `i_axi.rdy=0`.
  - `o_drop_cnt=0`.
- `i_axi.rdy` rises 1 cycle after `i_rst` deasserts.
- Latency: a beat accepted at edge k is visible on its lane after edge k (one register stage).
- Throughput: 1 beat/cycle with the selected lane held ready.
- Backpressure: lane `rdy` low → buffer fills in ≤2 cycles, then `i_axi.rdy=0`.
- Simultaneous push and pop with 2 entries: illegal by construction, since `rdy` was 0.
- Simultaneous push and pop with 1 entry: occupancy stays 1.
- Output `val` and payload hold steady while the lane's `rdy` is low.
- Reset mid-packet: buffered beats are discarded and the FSM returns to IDLE. No partial-packet recovery is attempted.

## Configuration
- Macro: `PACKET_DEMUX_DROP_EN`.
- Defined:
  - A packet whose latched `sel` is ≥`NUM_OUT` is accepted (`rdy` as normal) but never enters the skid buffer.
  - `o_drop_cnt` increments once per dropped packet, on its start beat, saturating at 16'hFFFF.
- Undefined:
  - Out-of-range `sel` routes to lane 0.
  - `o_drop_cnt` port absent.

## Structure
- `packet_demux_pkg`: FSM state enum (`IDLE`, `ACTIVE`), skid-entry struct (`dat`, `sop`, `eop`, `err`, `mod`, `ctl`, `sel`), drop-counter width constant.
- Sub-module `packet_demux_skid`: generic 2-entry register slice with registered `rdy`, parameterised by entry type width. Reusable elsewhere.
- Top: FSM, sel latch, out-of-range check, lane fan-out.

## Test plan
- **Single-beat routing:** `NUM_OUT=8`, beat `sop=eop=1`, `ctl[7:5]=3'd5`, `dat=64'hA5` → `o_n_axi[5]` shows `val=1`, `dat=64'hA5` one cycle later; all other lanes `val=0`.
- **Per-packet lock:** 4-beat packet, first `ctl` sel=2, later beats sel=6 → all 4 beats on lane 2 in order; next packet with sel=6 goes to lane 6.
- **Backpressure:**
  - Lane 1 `rdy=0` for 5 cycles during an 8-beat stream → `i_axi.rdy=0` by the 3rd cycle, no beat lost or duplicated.
  - Lane 1 `rdy` returns → 1 beat/cycle drain.
- **CLR_SEL:** `CLR_SEL=1`, `ctl=8'hE7` to lane 7 → output `ctl=8'h07`.
- **Drop:** `NUM_OUT=5` with macro, sel=6, 3-beat packet → no lane `val`, `o_drop_cnt=1`. Without macro → the 3 beats appear on lane 0.
- **Reset mid-packet:** `i_rst` pulsed after beat 2 of 4 → all `val=0`, `rdy=0` during reset; next packet with `sop` routes correctly from IDLE.

Source files
------------

// File: rtl/packet_demux_pkg.sv
// Shared types and constants for the 1-to-N packet demux.
package packet_demux_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  localparam int unsigned DROP_CNT_BITS = 16;

  // Saturating increment for the dropped-packet counter.
  function automatic logic [DROP_CNT_BITS-1:0] sat_inc(input logic [DROP_CNT_BITS-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/packet_demux_skid.sv
// Generic 2-entry register slice with a registered input-ready.
// Entry 0 is the head; entry 1 only fills while the head is stalled.
module packet_demux_skid #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] in_dat_i,
  input  logic         in_val_i,
  output logic         in_rdy_o,
  output logic [W-1:0] out_dat_o,
  output logic         out_val_o,
  input  logic         out_rdy_i
);

  logic [W-1:0] slot0_q, slot0_d, slot1_q, slot1_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         rdy_q, rdy_d;
  logic         push, pop;

  // Next-state for slots, occupancy and the registered ready.
  always_comb begin
    push    = in_val_i && rdy_q;
    pop     = (cnt_q != 2'd0) && out_rdy_i;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    if (pop) begin
      if (cnt_q == 2'd2) slot0_d = slot1_q;
      else if (push)     slot0_d = in_dat_i;
    end else if (push) begin
      if (cnt_q == 2'd0) slot0_d = in_dat_i;
      else               slot1_d = in_dat_i;
    end
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    rdy_d = (cnt_d < 2'd2);
  end

  // Slice registers; ready stays low through reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot0_q <= '0;
      slot1_q <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
    end
  end

  assign in_rdy_o  = rdy_q;
  assign out_dat_o = slot0_q;
  assign out_val_o = (cnt_q != 2'd0);

endmodule

// File: rtl/packet_demux_1_to_n.sv
// 1-to-N packet demux: per-packet channel lock, one skid stage, lane fan-out.
// Optional feature macro: PACKET_DEMUX_DROP_EN (drop out-of-range packets
// and count them on o_drop_cnt; otherwise out-of-range routes to lane 0).
module packet_demux_1_to_n
  import packet_demux_pkg::*;
#(
  parameter int unsigned DAT_BYTS     = 8,
  parameter int unsigned DAT_BITS     = DAT_BYTS * 8,
  parameter int unsigned CTL_BITS     = 8,
  parameter int unsigned NUM_OUT      = 8,
  parameter int unsigned LOG2_NUM_OUT = (NUM_OUT == 1) ? 1 : $clog2(NUM_OUT),
  parameter int unsigned SEL_BIT      = CTL_BITS - LOG2_NUM_OUT,
  parameter int unsigned CLR_SEL      = 0,
  parameter int unsigned MOD_BITS     = (DAT_BYTS == 1) ? 1 : $clog2(DAT_BYTS)
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic [DAT_BITS-1:0]                i_axi_dat,
  input  logic                               i_axi_val,
  input  logic                               i_axi_sop,
  input  logic                               i_axi_eop,
  input  logic                               i_axi_err,
  input  logic [MOD_BITS-1:0]                i_axi_mod,
  input  logic [CTL_BITS-1:0]                i_axi_ctl,
  output logic                               i_axi_rdy,
  output logic [NUM_OUT-1:0][DAT_BITS-1:0]   o_n_axi_dat,
  output logic [NUM_OUT-1:0]                 o_n_axi_val,
  output logic [NUM_OUT-1:0]                 o_n_axi_sop,
  output logic [NUM_OUT-1:0]                 o_n_axi_eop,
  output logic [NUM_OUT-1:0]                 o_n_axi_err,
  output logic [NUM_OUT-1:0][MOD_BITS-1:0]   o_n_axi_mod,
  output logic [NUM_OUT-1:0][CTL_BITS-1:0]   o_n_axi_ctl,
  input  logic [NUM_OUT-1:0]                 o_n_axi_rdy
`ifdef PACKET_DEMUX_DROP_EN
  ,
  output logic [DROP_CNT_BITS-1:0]           o_drop_cnt
`endif
);

  typedef struct packed {
    logic [DAT_BITS-1:0]     dat;
    logic                    sop;
    logic                    eop;
    logic                    err;
    logic [MOD_BITS-1:0]     mod;
    logic [CTL_BITS-1:0]     ctl;
    logic [LOG2_NUM_OUT-1:0] sel;
  } entry_t;

  localparam int unsigned ENTRY_W  = $bits(entry_t);
  localparam bit          SEL_POW2 = ((1 << LOG2_NUM_OUT) == NUM_OUT);

  state_e                  state_q, state_d;
  logic [LOG2_NUM_OUT-1:0] sel_q, sel_d, beat_sel, lat_sel, route_sel;
  logic                    acc, start, beat_in_range, cur_drop;
  entry_t                  in_entry, head;
  logic [ENTRY_W-1:0]      head_bits;
  logic                    head_val, head_rdy;
  logic [CTL_BITS-1:0]     out_ctl;

  assign beat_sel = i_axi_ctl[SEL_BIT +: LOG2_NUM_OUT];
  assign acc      = i_axi_val && i_axi_rdy;
  // A beat starts a packet when idle, or when sop arrives before the previous eop.
  assign start    = (state_q == IDLE) || i_axi_sop;

  if (SEL_POW2) begin : g_pow2
    assign beat_in_range = 1'b1;
  end else begin : g_npow2
    assign beat_in_range = ({1'b0, beat_sel} < (LOG2_NUM_OUT + 1)'(NUM_OUT));
  end

`ifdef PACKET_DEMUX_DROP_EN
  logic                     drop_q, drop_d;
  logic [DROP_CNT_BITS-1:0] drop_cnt_q, drop_cnt_d;

  assign lat_sel = beat_sel;

  // Per-packet drop flag and saturating drop count, updated on start beats.
  always_comb begin
    drop_d     = drop_q;
    drop_cnt_d = drop_cnt_q;
    cur_drop   = start ? !beat_in_range : drop_q;
    if (acc && start) begin
      drop_d = !beat_in_range;
      if (!beat_in_range) drop_cnt_d = sat_inc(drop_cnt_q);
    end
  end

  // Drop flag and counter registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      drop_q     <= drop_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign o_drop_cnt = drop_cnt_q;
`else
  assign lat_sel  = beat_in_range ? beat_sel : '0;
  assign cur_drop = 1'b0;
`endif

  // FSM next-state and channel latch.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    if (acc) begin
      if (start) sel_d = lat_sel;
      state_d = i_axi_eop ? IDLE : ACTIVE;
    end
  end

  // FSM state and latched channel.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  assign route_sel = start ? lat_sel : sel_q;

  // Pack the incoming beat with its routing tag.
  always_comb begin
    in_entry.dat = i_axi_dat;
    in_entry.sop = i_axi_sop;
    in_entry.eop = i_axi_eop;
    in_entry.err = i_axi_err;
    in_entry.mod = i_axi_mod;
    in_entry.ctl = i_axi_ctl;
    in_entry.sel = route_sel;
  end

  packet_demux_skid #(
    .W (ENTRY_W)
  ) u_skid (
    .clk_i     (i_clk),
    .rst_i     (i_rst),
    .in_dat_i  (in_entry),
    .in_val_i  (i_axi_val && !cur_drop),
    .in_rdy_o  (i_axi_rdy),
    .out_dat_o (head_bits),
    .out_val_o (head_val),
    .out_rdy_i (head_rdy)
  );

  assign head = head_bits;

  // Fan the head entry out to every lane; only the tagged lane sees val.
  always_comb begin
    out_ctl = head.ctl;
    if (CLR_SEL != 0) out_ctl[SEL_BIT +: LOG2_NUM_OUT] = '0;
    for (int unsigned i = 0; i < NUM_OUT; i++) begin
      o_n_axi_val[i] = head_val && (head.sel == LOG2_NUM_OUT'(i));
      o_n_axi_dat[i] = head.dat;
      o_n_axi_sop[i] = head.sop;
      o_n_axi_eop[i] = head.eop;
      o_n_axi_err[i] = head.err;
      o_n_axi_mod[i] = head.mod;
      o_n_axi_ctl[i] = out_ctl;
    end
  end

  assign head_rdy = |(o_n_axi_rdy & o_n_axi_val);

endmodule
